// File: rtl/exec_stage.sv
// exec_stage: pipeline execute stage.
//   Single-cycle ALU for ops 0-10. DIVU/REMU with a nonzero divisor use an
//   iterative restoring divider that produces one quotient bit per cycle.
//   DIVU/REMU with a zero divisor complete in one cycle.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   de_*              decoded instruction: pc, operands, store data, op,
//                     destination register, class flags
//   icache_stall,
//   dcache_stall      freeze requests; output registers hold while either is high
//   ac_*, ALU_result  registered results for the memory stage
//   ex_stall          divider busy; upstream must hold its de_* outputs
module exec_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] de_pc,
  input  logic [31:0] de_a,
  input  logic [31:0] de_b,
  input  logic [31:0] de_data2,
  input  logic [3:0]  de_op,
  input  logic [4:0]  de_write_sel,
  input  logic        de_is_load,
  input  logic        de_is_store,
  input  logic        de_is_wb,
  input  logic        icache_stall,
  input  logic        dcache_stall,
  output logic [31:0] ac_pc,
  output logic [4:0]  ac_write_sel,
  output logic [31:0] ALU_result,
  output logic [31:0] ac_data2,
  output logic        ac_is_load,
  output logic        ac_is_store,
  output logic        ac_is_wb,
  output logic        ex_stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [31:0] div_rem, div_quot, div_divisor;
  logic        div_is_rem;
  logic [31:0] lat_pc, lat_data2;
  logic [4:0]  lat_write_sel;
  logic        lat_is_load, lat_is_store, lat_is_wb;

  logic        is_div_op, div_start, out_en;
  logic [31:0] alu_result;
  logic [32:0] div_shifted;
  logic [33:0] div_trial;
  logic [31:0] step_rem, step_quot;

  assign is_div_op = (de_op == 4'd11) || (de_op == 4'd12);
  assign div_start = (state == IDLE) && is_div_op && (de_b != '0);
  assign out_en    = !icache_stall && !dcache_stall;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (div_start) state_next = BUSY;
      BUSY:    if (count == '0) state_next = DONE;
      DONE:    if (out_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ex_stall = div_start || (state == BUSY);
  end

  // Single-cycle ALU; divide ops here only cover the zero-divisor case
  always_comb begin
    alu_result = '0;
    case (de_op)
      4'd0:  alu_result = de_a + de_b;
      4'd1:  alu_result = de_a - de_b;
      4'd2:  alu_result = de_a & de_b;
      4'd3:  alu_result = de_a | de_b;
      4'd4:  alu_result = de_a ^ de_b;
      4'd5:  alu_result = de_a << de_b[4:0];
      4'd6:  alu_result = de_a >> de_b[4:0];
      4'd7:  alu_result = $unsigned($signed(de_a) >>> de_b[4:0]);
      4'd8:  alu_result = {31'd0, $signed(de_a) < $signed(de_b)};
      4'd9:  alu_result = {31'd0, de_a < de_b};
      4'd10: alu_result = de_a * de_b;
      4'd11: alu_result = '1;
      4'd12: alu_result = de_a;
      default: alu_result = '0;
    endcase
  end

  // Restoring divide step: the dividend is shifted out of div_quot MSB-first
  // while quotient bits are shifted in at the bottom. The partial remainder
  // is always below the divisor, so the shifted value fits in 33 bits and a
  // 34-bit trial subtraction exposes the borrow in bit 33.
  always_comb begin
    div_shifted = {div_rem, div_quot[31]};
    div_trial   = {1'b0, div_shifted} - {2'b00, div_divisor};
    if (!div_trial[33]) begin
      step_rem  = div_trial[31:0];
      step_quot = {div_quot[30:0], 1'b1};
    end else begin
      step_rem  = div_shifted[31:0];
      step_quot = {div_quot[30:0], 1'b0};
    end
  end

  // Divider datapath and latched control fields
  always_ff @(posedge clock) begin
    if (reset) begin
      count         <= '0;
      div_rem       <= '0;
      div_quot      <= '0;
      div_divisor   <= '0;
      div_is_rem    <= 1'b0;
      lat_pc        <= '0;
      lat_data2     <= '0;
      lat_write_sel <= '0;
      lat_is_load   <= 1'b0;
      lat_is_store  <= 1'b0;
      lat_is_wb     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (div_start) begin
          count         <= 5'd31;
          div_rem       <= '0;
          div_quot      <= de_a;
          div_divisor   <= de_b;
          div_is_rem    <= (de_op == 4'd12);
          lat_pc        <= de_pc;
          lat_data2     <= de_data2;
          lat_write_sel <= de_write_sel;
          lat_is_load   <= de_is_load;
          lat_is_store  <= de_is_store;
          lat_is_wb     <= de_is_wb;
        end
        BUSY: begin
          count    <= count - 5'd1;
          div_rem  <= step_rem;
          div_quot <= step_quot;
        end
        default: ;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ac_pc        <= '0;
      ac_write_sel <= '0;
      ALU_result   <= '0;
      ac_data2     <= '0;
      ac_is_load   <= 1'b0;
      ac_is_store  <= 1'b0;
      ac_is_wb     <= 1'b0;
    end else if (out_en) begin
      if (state == DONE) begin
        ac_pc        <= lat_pc;
        ac_write_sel <= lat_write_sel;
        ALU_result   <= div_is_rem ? div_rem : div_quot;
        ac_data2     <= lat_data2;
        ac_is_load   <= lat_is_load;
        ac_is_store  <= lat_is_store;
        ac_is_wb     <= lat_is_wb;
      end else if (ex_stall) begin
        ac_pc        <= '0;
        ac_write_sel <= '0;
        ALU_result   <= '0;
        ac_data2     <= '0;
        ac_is_load   <= 1'b0;
        ac_is_store  <= 1'b0;
        ac_is_wb     <= 1'b0;
      end else begin
        ac_pc        <= de_pc;
        ac_write_sel <= de_write_sel;
        ALU_result   <= alu_result;
        ac_data2     <= de_data2;
        ac_is_load   <= de_is_load;
        ac_is_store  <= de_is_store;
        ac_is_wb     <= de_is_wb;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: scoreboard bench for exec_stage. The driver applies one
// input set per cycle, steps a latency-level reference model and queues the
// expected ex_stall for that cycle and the expected outputs after the edge;
// independent monitors pop and compare.
module tb_exec_stage;

  logic        clock = 1'b1;
  logic        reset;
  logic [31:0] de_pc, de_a, de_b, de_data2;
  logic [3:0]  de_op;
  logic [4:0]  de_write_sel;
  logic        de_is_load, de_is_store, de_is_wb;
  logic        icache_stall, dcache_stall;
  logic [31:0] ac_pc, ALU_result, ac_data2;
  logic [4:0]  ac_write_sel;
  logic        ac_is_load, ac_is_store, ac_is_wb, ex_stall;

  exec_stage dut (
    .clock(clock), .reset(reset),
    .de_pc(de_pc), .de_a(de_a), .de_b(de_b), .de_data2(de_data2),
    .de_op(de_op), .de_write_sel(de_write_sel),
    .de_is_load(de_is_load), .de_is_store(de_is_store), .de_is_wb(de_is_wb),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .ac_pc(ac_pc), .ac_write_sel(ac_write_sel), .ALU_result(ALU_result),
    .ac_data2(ac_data2), .ac_is_load(ac_is_load), .ac_is_store(ac_is_store),
    .ac_is_wb(ac_is_wb), .ex_stall(ex_stall)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  ws;
    logic [31:0] res;
    logic [31:0] d2;
    logic        ld, st, wb;
  } out_t;

  typedef struct { int unsigned e; out_t o; } oexp_t;
  typedef struct { int unsigned e; logic s; } sexp_t;

  oexp_t oq[$];
  sexp_t sq[$];
  int unsigned edge_cnt = 0;
  int compared = 0;
  int mismatched = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Reference model: divides take 32 busy cycles after presentation, then
  // wait for the first unstalled edge to emit.
  out_t m_out, m_pend;
  int   m_left = 0;
  bit   m_wait = 0;
  bit   m_known = 0;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return $unsigned($signed(a) >>> sh);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return a * b;
      4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit long_div();
    return ((de_op == 4'd11) || (de_op == 4'd12)) && (de_b != 0);
  endfunction

  function automatic bit model_stall();
    return (m_left > 0) || (!m_wait && m_left == 0 && long_div());
  endfunction

  task automatic tick();
    bit en;
    sexp_t s;
    oexp_t o;
    en = !icache_stall && !dcache_stall;
    if (m_known) begin
      s.e = edge_cnt + 1;
      s.s = model_stall();
      sq.push_back(s);
    end
    if (reset) begin
      m_out = '0; m_left = 0; m_wait = 0; m_known = 1;
    end else if (m_known) begin
      if (m_wait) begin
        if (en) begin m_out = m_pend; m_wait = 0; end
      end else if (m_left > 0) begin
        if (en) m_out = '0;
        m_left--;
        if (m_left == 0) m_wait = 1;
      end else if (long_div()) begin
        m_pend = '{de_pc, de_write_sel, ref_alu(de_op, de_a, de_b), de_data2,
                   de_is_load, de_is_store, de_is_wb};
        m_left = 32;
        if (en) m_out = '0;
      end else if (en) begin
        m_out = '{de_pc, de_write_sel, ref_alu(de_op, de_a, de_b), de_data2,
                  de_is_load, de_is_store, de_is_wb};
      end
    end
    if (m_known) begin
      o.e = edge_cnt + 1;
      o.o = m_out;
      oq.push_back(o);
    end
    @(posedge clock);
    #1;
  endtask

  // ex_stall monitor: combinational output, sampled mid-cycle
  initial forever begin
    sexp_t s;
    @(negedge clock);
    if (sq.size() > 0 && sq[0].e == edge_cnt + 1) begin
      s = sq.pop_front();
      compared++;
      if (ex_stall !== s.s) begin
        mismatched++;
        $display("FAIL ex_stall cycle %0d: got %b exp %b", s.e, ex_stall, s.s);
      end
    end
  end

  // Output-register monitor
  initial forever begin
    oexp_t o;
    out_t  got;
    @(posedge clock);
    #2;
    if (oq.size() > 0 && oq[0].e == edge_cnt) begin
      o = oq.pop_front();
      got = '{ac_pc, ac_write_sel, ALU_result, ac_data2, ac_is_load, ac_is_store, ac_is_wb};
      compared++;
      if (got !== o.o) begin
        mismatched++;
        $display("FAIL outputs edge %0d: got pc=%h ws=%0d res=%h d2=%h f=%b%b%b exp pc=%h ws=%0d res=%h d2=%h f=%b%b%b",
                 o.e, got.pc, got.ws, got.res, got.d2, got.ld, got.st, got.wb,
                 o.o.pc, o.o.ws, o.o.res, o.o.d2, o.o.ld, o.o.st, o.o.wb);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h exp %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    de_op = op; de_a = a; de_b = b;
    de_pc = de_pc + 32'd4;
    de_data2 = $urandom;
    de_write_sel = 5'($urandom_range(1, 31));
    de_is_load = 1'b0; de_is_store = 1'b1; de_is_wb = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    de_pc = 32'h0000_1000; de_a = '0; de_b = '0; de_data2 = '0; de_op = '0;
    de_write_sel = '0; de_is_load = 0; de_is_store = 0; de_is_wb = 0;
    icache_stall = 0; dcache_stall = 0;
    tick(); tick();
    chk("reset_result", ALU_result, 32'd0);
    reset = 1'b0;

    issue(4'd0, 32'd5, 32'hFFFF_FFFF); tick();
    chk("add", ALU_result, 32'd4);
    chk("add_pc", ac_pc, de_pc);
    issue(4'd7, 32'h8000_0000, 32'd4); tick();
    chk("sra", ALU_result, 32'hF800_0000);
    issue(4'd9, 32'd1, 32'hFFFF_FFFF); tick();
    chk("sltu", ALU_result, 32'd1);
    issue(4'd8, 32'd1, 32'hFFFF_FFFF); tick();
    chk("slt", ALU_result, 32'd0);

    issue(4'd11, 32'd100, 32'd7); repeat (34) tick();
    chk("divu", ALU_result, 32'd14);
    issue(4'd12, 32'd100, 32'd7); repeat (34) tick();
    chk("remu", ALU_result, 32'd2);
    issue(4'd11, 32'd9, 32'd0); tick();
    chk("divu_zero", ALU_result, 32'hFFFF_FFFF);
    issue(4'd12, 32'd9, 32'd0); tick();
    chk("remu_zero", ALU_result, 32'd9);

    // Long dcache freeze across the whole divide
    issue(4'd11, 32'd1000, 32'd3); tick();
    dcache_stall = 1'b1;
    repeat (40) tick();
    chk("frozen_result", ALU_result, 32'd0);
    dcache_stall = 1'b0; tick();
    chk("divu_after_freeze", ALU_result, 32'd333);
    issue(4'd1, 32'd10, 32'd3); tick();
    chk("sub_after_div", ALU_result, 32'd7);

    // Reset in the middle of a divide
    issue(4'd11, 32'hFFFF_FFFF, 32'd5); tick();
    repeat (10) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_result", ALU_result, 32'd0);
    issue(4'd0, 32'd20, 32'd22); tick();
    chk("add_after_abort", ALU_result, 32'd42);

    // Randomized traffic; inputs held while the model says upstream is stalled
    for (int i = 0; i < 700; i++) begin
      if (!model_stall()) begin
        int unsigned sel;
        de_pc = $urandom; de_data2 = $urandom;
        de_write_sel = 5'($urandom); de_is_load = 1'($urandom);
        de_is_store = 1'($urandom); de_is_wb = 1'($urandom);
        de_op = ($urandom_range(0, 3) == 0) ? 4'(11 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
        de_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
        sel = $urandom_range(0, 19);
        if (sel < 3) de_b = '0;
        else if (sel < 8) de_b = 32'($urandom_range(1, 40));
        else de_b = $urandom;
      end
      icache_stall = ($urandom_range(0, 9) == 0);
      dcache_stall = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0; icache_stall = 0; dcache_stall = 0;
    #6;
    compared++;
    if (oq.size() != 0 || sq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d/%0d pending exp 0/0", oq.size(), sq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- de_pc  in  32  PC of decoded instruction
- de_a  in  32  operand A (rs1 value)
- de_b  in  32  operand B (rs2 value or immediate)
- de_data2  in  32  rs2 value, used as store data
- de_op  in  4  ALU operation code
- de_write_sel  in  5  destination register
- de_is_load, de_is_store, de_is_wb  in  1 each  instruction class flags
- icache_stall, dcache_stall  in  1 each  external freeze requests
- ac_pc  out  32  registered PC to the memory stage
- ac_write_sel  out  5  registered destination register
- ALU_result  out  32  registered result, also the memory address
- ac_data2  out  32  registered store data
- ac_is_load, ac_is_store, ac_is_wb  out  1 each  registered flags
- ex_stall  out  1  execute-stage busy; upstream holds its de_* outputs

Function
REQ-003 SHALL decode de_op as:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
- 5 SLL, 6 SRL, 7 SRA (shift amount de_b[4:0])
- 8 SLT (signed, result 1/0), 9 SLTU (unsigned, result 1/0)
- 10 MUL (low 32 bits of the product)
- 11 DIVU (unsigned quotient), 12 REMU (unsigned remainder)
- 13-15 result 0
REQ-004 SHALL wrap all arithmetic modulo 2^32, with no overflow flag.
REQ-005 SHALL compute ops 0-10 in one cycle.
REQ-006 SHALL compute DIVU/REMU with a nonzero divisor in an iterative restoring divider, one quotient bit per cycle, 32 iterations.
REQ-007 SHALL implement divider FSM states IDLE, BUSY, DONE.
REQ-008 SHALL transition IDLE->BUSY when de_op is 11 or 12 and de_b != 0, latching operands, op and control fields, and loading the iteration counter with 31.
REQ-009 SHALL decrement the counter once per cycle in BUSY and go BUSY->DONE on the cycle the counter is 0 (32 BUSY cycles).
REQ-010 SHALL go DONE->IDLE on the first edge where icache_stall=0 and dcache_stall=0, loading the latched result and control fields into the output registers on that edge.
REQ-011 SHALL keep the divider running in BUSY regardless of icache_stall and dcache_stall.
REQ-012 SHALL complete DIVU/REMU with de_b == 0 in one cycle without entering BUSY: DIVU gives 0xFFFFFFFF, REMU gives de_a.
REQ-013 SHALL drive ex_stall = (IDLE and de_op in {11,12} and de_b != 0) or BUSY, combinationally; ex_stall SHALL be 0 in DONE.
REQ-014 SHALL update all output registers only on edges where icache_stall=0 and dcache_stall=0; otherwise all outputs hold.
REQ-015 SHALL, on an enabled edge with ex_stall=0 in IDLE, load ac_pc=de_pc, ac_write_sel=de_write_sel, ALU_result=the result, ac_data2=de_data2, and the three flags from de_*.
REQ-016 SHALL, on an enabled edge with ex_stall=1, load a bubble: all flags 0, ac_pc/ac_write_sel/ALU_result/ac_data2 all 0.
REQ-017 SHALL ignore the de_* inputs while in BUSY or DONE; upstream holds them because ex_stall was high.
REQ-018 SHALL give a nonzero-divisor divide 34 cycles from presentation to output when unstalled: 1 cycle entering BUSY, 32 BUSY cycles, 1 DONE cycle, with the result visible after the DONE edge.

Reset
REQ-019 SHALL, on reset=1 at a rising edge, clear all outputs to 0, set the FSM to IDLE and clear the counter and divider registers, overriding all stalls.
REQ-020 SHALL, on reset during BUSY or DONE, abort the division with no result emitted; ex_stall SHALL be 0 in the following cycle unless a nonzero-divisor divide is presented.

Verification
REQ-021 SHALL be verified by a bench covering these directed scenarios:
- Reset, then ADD de_a=5 de_b=0xFFFFFFFF, no stalls -> next edge ALU_result=4; flags and de_pc are passed through.
- SRA de_a=0x80000000 de_b=4 -> ALU_result=0xF8000000; SLTU de_a=1 de_b=0xFFFFFFFF -> 1; SLT with the same operands -> 0.
- DIVU de_a=100 de_b=7 -> ex_stall high for 33 cycles, output bubbles during the stall, then ALU_result=14; REMU with the same operands -> 2.
- DIVU de_b=0, de_a=9 -> 1 cycle, ALU_result=0xFFFFFFFF, ex_stall never high; REMU de_b=0 -> ALU_result=9.
- dcache_stall held high 40 cycles during a DIVU -> outputs frozen throughout; result emitted on the first unstalled edge after DONE.
- Reset asserted at BUSY iteration 10 -> all outputs 0, FSM IDLE, no quotient emitted; a following ADD executes normally.
